// File: rtl/cceip_kernel_counter_pkg.sv
// Shared types and slice helpers for the CCEIP kernel counter bank.
package cceip_kernel_counter_pkg;

  typedef enum logic [0:0] {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } counter_mode_e;

  localparam int unsigned DEFAULT_CHANNELS   = 4;
  localparam int unsigned DEFAULT_WIDTH      = 16;
  localparam int unsigned DEFAULT_STEP_WIDTH = 4;

  typedef struct packed {
    logic is_zero;
    logic thresh_hit;
    logic ovf;
    logic unf;
  } lane_flags_t;

  // Bit offset of a lane inside a packed per-lane vector.
  function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cceip_kernel_counter_lane.sv
// One up/down counter lane: next-state arithmetic, sticky flags and
// zero/threshold compares, all registered together with the count.
import cceip_kernel_counter_pkg::*;

module cceip_kernel_counter_lane #(
  parameter int unsigned C_WIDTH      = 16,
  parameter int unsigned C_STEP_WIDTH = 4,
  parameter counter_mode_e C_MODE     = WRAP,
  parameter logic [C_WIDTH-1:0] C_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clken,
  input  logic                    load,
  input  logic [C_WIDTH-1:0]      load_value,
  input  logic                    incr,
  input  logic                    decr,
  input  logic [C_STEP_WIDTH-1:0] step,
  input  logic [C_WIDTH-1:0]      threshold,
  input  logic                    flag_clr,
  output logic [C_WIDTH-1:0]      count,
  output lane_flags_t             flags
);

  logic [C_WIDTH-1:0] count_reg;
  logic [C_WIDTH-1:0] count_next;
  logic               is_zero_reg;
  logic               thresh_hit_reg;
  logic               ovf_reg;
  logic               unf_reg;
  logic               ovf_set;
  logic               unf_set;
  logic [C_WIDTH:0]   step_ext;
  logic [C_WIDTH:0]   sum;
  logic [C_WIDTH:0]   diff;

  // The extra top bit carries the overflow / borrow condition.
  assign step_ext = {{(C_WIDTH + 1 - C_STEP_WIDTH){1'b0}}, step};
  assign sum      = {1'b0, count_reg} + step_ext;
  assign diff     = {1'b0, count_reg} - step_ext;

  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (incr && !decr) begin
      ovf_set    = sum[C_WIDTH];
      count_next = (ovf_set && C_MODE == SATURATE) ? '1 : sum[C_WIDTH-1:0];
    end else if (decr && !incr) begin
      unf_set    = diff[C_WIDTH];
      count_next = (unf_set && C_MODE == SATURATE) ? '0 : diff[C_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= C_INIT;
      is_zero_reg    <= (C_INIT == '0);
      thresh_hit_reg <= (C_INIT >= threshold);
      ovf_reg        <= 1'b0;
      unf_reg        <= 1'b0;
    end else if (clken) begin
      count_reg      <= count_next;
      is_zero_reg    <= (count_next == '0);
      thresh_hit_reg <= (count_next >= threshold);
      ovf_reg        <= ovf_set | (ovf_reg & ~flag_clr);
      unf_reg        <= unf_set | (unf_reg & ~flag_clr);
    end
  end

  assign count            = count_reg;
  assign flags.is_zero    = is_zero_reg;
  assign flags.thresh_hit = thresh_hit_reg;
  assign flags.ovf        = ovf_reg;
  assign flags.unf        = unf_reg;

endmodule

// File: rtl/cceip_kernel_multi_counter.sv
// Bank of independent up/down counter lanes; packs and unpacks the
// per-lane vectors around one counter_lane instance per channel.
import cceip_kernel_counter_pkg::*;

module cceip_kernel_multi_counter #(
  parameter int unsigned C_CHANNELS   = DEFAULT_CHANNELS,
  parameter int unsigned C_WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned C_STEP_WIDTH = DEFAULT_STEP_WIDTH,
  parameter int unsigned C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clken,
  input  logic [C_CHANNELS-1:0]              load,
  input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
  input  logic [C_CHANNELS-1:0]              incr,
  input  logic [C_CHANNELS-1:0]              decr,
  input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
  input  logic [C_WIDTH-1:0]                 threshold,
  input  logic [C_CHANNELS-1:0]              flag_clr,
  output logic [C_CHANNELS*C_WIDTH-1:0]      count,
  output logic [C_CHANNELS-1:0]              is_zero,
  output logic [C_CHANNELS-1:0]              thresh_hit,
  output logic [C_CHANNELS-1:0]              ovf,
  output logic [C_CHANNELS-1:0]              unf
);

  localparam counter_mode_e MODE = (C_SATURATE != 0) ? SATURATE : WRAP;

  lane_flags_t flags [C_CHANNELS];

  generate
    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_lane
      localparam int unsigned CB = lane_base(gi, C_WIDTH);
      localparam int unsigned SB = lane_base(gi, C_STEP_WIDTH);

      cceip_kernel_counter_lane #(
        .C_WIDTH      (C_WIDTH),
        .C_STEP_WIDTH (C_STEP_WIDTH),
        .C_MODE       (MODE),
        .C_INIT       (C_INIT)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .load       (load[gi]),
        .load_value (load_value[CB +: C_WIDTH]),
        .incr       (incr[gi]),
        .decr       (decr[gi]),
        .step       (step[SB +: C_STEP_WIDTH]),
        .threshold  (threshold),
        .flag_clr   (flag_clr[gi]),
        .count      (count[CB +: C_WIDTH]),
        .flags      (flags[gi])
      );

      assign is_zero[gi]    = flags[gi].is_zero;
      assign thresh_hit[gi] = flags[gi].thresh_hit;
      assign ovf[gi]        = flags[gi].ovf;
      assign unf[gi]        = flags[gi].unf;
    end
  endgenerate

endmodule

// File: doc/cceip_kernel_multi_counter.md
# cceip_kernel_multi_counter

Parametrised bank of independent up/down counters for the CCEIP kernel control path, tracking outstanding AXI transactions, beat counts and credits per channel. Generalises the single-lane example counter with N channels, variable step size, selectable wrap/saturate mode, a programmable threshold compare and sticky overflow/underflow flags. Every flag is registered and coherent with `count` in the same cycle, so downstream FSMs can use `is_zero` and `thresh_hit` without a compare stage.

## Interface
- `C_CHANNELS`, 4: number of independent counter lanes (1..32).
- `C_WIDTH`, 16: counter width per lane (2..64).
- `C_STEP_WIDTH`, 4: width of the per-lane step magnitude (1..C_WIDTH).
- `C_SATURATE`, 0: 0 selects modulo-2^C_WIDTH wrap; 1 selects clamping at 0 and at all-ones.
- `C_INIT`, 0: reset/init value, C_WIDTH bits, applied to all lanes.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clken`  in  1  global enable; when low, all state holds (flag clears included).
- `load`  in  C_CHANNELS  per-lane load strobe.
- `load_value`  in  C_CHANNELS*C_WIDTH  packed load values; lane i occupies bits [i*C_WIDTH +: C_WIDTH].
- `incr`  in  C_CHANNELS  per-lane increment request.
- `decr`  in  C_CHANNELS  per-lane decrement request.
- `step`  in  C_CHANNELS*C_STEP_WIDTH  packed unsigned step magnitude per lane.
- `threshold`  in  C_WIDTH  shared compare threshold (quasi-static).
- `flag_clr`  in  C_CHANNELS  per-lane clear of the sticky flags.
- `count`  out  C_CHANNELS*C_WIDTH  packed registered counts.
- `is_zero`  out  C_CHANNELS  registered; count == 0.
- `thresh_hit`  out  C_CHANNELS  registered; count >= threshold.
- `ovf`  out  C_CHANNELS  sticky; set when an increment would exceed all-ones.
- `unf`  out  C_CHANNELS  sticky; set when a decrement would go below 0.

## Operation
- Per-lane priority, evaluated only while `clken`=1: `load` > (`incr` XOR `decr`) > hold. `incr`=`decr`=1 holds the count.
- Step: the count changes by the zero-extended `step`. A step of 0 holds the count and cannot raise `ovf`/`unf`.
- Arithmetic: computed at C_WIDTH+1 bits. The carry or borrow bit is the overflow or underflow condition.
  - Wrap mode: the result is truncated to C_WIDTH bits.
  - Saturate mode: the result clamps to all-ones on overflow and to 0 on underflow.
- Sticky flags:
  - `ovf`/`unf` are set on the cycle the condition occurs, in both modes.
  - They clear on `flag_clr`. If a clear and a set coincide, the set wins.
  - `load` does not clear them.
- `is_zero` and `thresh_hit` are computed from the next-state value and registered alongside `count`. They are never one cycle stale.
- Lanes are fully independent. No cross-lane carry and no shared arbitration.

## Timing
- Reset: every lane `count`=C_INIT, `is_zero`=(C_INIT==0), `thresh_hit`=(C_INIT>=`threshold` sampled during reset), `ovf`=`unf`=0.
- Latency: one cycle from an input strobe to the updated `count` and flags.
- `threshold` changes take effect on the next cycle that performs a state update with `clken`=1.
- `clken`=0: all registers hold, including sticky flags, and `flag_clr` is ignored.
- `rst` asserted mid-operation overrides everything on that edge, including `load`.
- Boundaries (C_WIDTH=4, wrap mode):
  - Count 15, `incr` step 1 gives 0 with `is_zero`=1 and `ovf`=1.
  - Count 0, `decr` step 3 gives 13 with `unf`=1.

## Structure
- Package `cceip_kernel_counter_pkg` holds:
  - the `counter_mode_e` enum (WRAP, SATURATE);
  - the lane-slice helper localparams;
  - the `lane_flags_t` struct (`is_zero`, `thresh_hit`, `ovf`, `unf`).
- Sub-module `cceip_kernel_counter_lane` implements one lane: next-state arithmetic, flag registers and compare. The top level is a generate loop that instantiates one lane per channel and packs/unpacks the vectors.
- Target size is about 200 RTL lines in total.

## Test plan
- Reset with C_INIT=5 and `threshold`=5: all lanes read 5, `is_zero`=0, `thresh_hit`=1, `ovf`=`unf`=0.
- Lane 0 `incr` step 3 and lane 1 `decr` step 2 in the same cycle, from 5: the next cycle reads lane0=8 and lane1=3, with other lanes unchanged.
- Wrap, C_WIDTH=4: lane at 14, `incr` step 4 gives 2 with `ovf`=1. `ovf` stays 1 until `flag_clr`. A simultaneous `flag_clr` and a new overflow leaves `ovf`=1.
- Saturate: lane at 1, `decr` step 4 gives 0 with `is_zero`=1 and `unf`=1. A further `incr` step 15 from 0 gives 15, and a further `incr` then holds 15 with `ovf`=1.
- Priority: `load`=1 with `load_value`=9 together with `incr`=`decr`=1 gives 9. `incr`=`decr`=1 alone holds the count. `clken`=0 with `load` holds the count.
- Reset asserted mid-stream during `load`: the lane returns to C_INIT and the flags clear on that edge.
